// File: rtl/id_regfile_sb_if.sv
// Bundle between the decode stage (master) and the register file with its
// pending-write scoreboard (slave).
interface id_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_used;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_dest;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     clr_pend;
  logic                     stall;
  logic                     pend_full;
  logic                     err;

  modport master (
    output rd_addr, rd_used, iss_en, iss_dest, wr_en, wr_addr, wr_data, clr_pend,
    input  rd_data, rd_busy, stall, pend_full, err
  );

  modport slave (
    input  rd_addr, rd_used, iss_en, iss_dest, wr_en, wr_addr, wr_data, clr_pend,
    output rd_data, rd_busy, stall, pend_full, err
  );
endinterface

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with write-through bypass and a per-register
// pending-write counter that drives the RAW-hazard stall.
module id_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int MAX_PEND = 3
) (
  input  logic           clk,
  input  logic           rst,
  id_regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PEND);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CW-1:0]     cnt  [DEPTH];
  logic              err_q;
  logic [NUM_RD-1:0] busy;
  logic              pend_full;
  logic              stall;
  logic [DEPTH-1:0]  inc_vec;
  logic [DEPTH-1:0]  dec_vec;

  // A write landing this cycle is forwarded, and a counter about to drop to
  // zero no longer blocks the reader.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              wr_hit;
    assign addr   = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign wr_hit = bus.wr_en && (bus.wr_addr == addr) && (addr != '0);
    assign bus.rd_data[k*DATA_W +: DATA_W] = wr_hit ? bus.wr_data : regs[addr];
    assign busy[k] = (cnt[addr] != '0) && !(wr_hit && (cnt[addr] == CNT_ONE));
  end

  assign pend_full = bus.iss_en && (bus.iss_dest != '0) && (cnt[bus.iss_dest] == CNT_MAX)
                     && !(bus.wr_en && (bus.wr_addr == bus.iss_dest));
  assign stall = pend_full || |(bus.rd_used & busy);

  assign bus.stall     = stall;
  assign bus.pend_full = pend_full;
  assign bus.rd_busy   = busy;
  assign bus.err       = err_q;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (bus.iss_en && !stall && (bus.iss_dest != '0)) inc_vec[bus.iss_dest] = 1'b1;
    if (bus.wr_en && (bus.wr_addr != '0))              dec_vec[bus.wr_addr]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= DATA_W'(i);
        cnt[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (bus.wr_en && (bus.wr_addr != '0)) begin
        regs[bus.wr_addr] <= bus.wr_data;
        if (cnt[bus.wr_addr] == '0) err_q <= 1'b1;
      end
      // Register 0 is never tracked, so its counter stays at its reset value.
      for (int r = 1; r < DEPTH; r++) begin
        if (bus.clr_pend)
          cnt[r] <= '0;
        else if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end
endmodule
